// File: rtl/pixel_array_sequencer.sv
// pixel_array_sequencer
//   Frame controller for the pixel array and its shared ramp ADC. One frame
//   runs erase -> expose -> convert (ramp 0 .. 2^ADC_BITS-1) -> row-by-row
//   readout. It then returns to idle, or starts the next frame directly when
//   continuous is high in the last readout cycle.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   start       frame request, sampled only while idle
//   continuous  chain the next frame, sampled only in the last readout cycle
//   erase       pixel erase control (ERASE phase)
//   expose      pixel exposure control (EXPOSE phase)
//   convert     comparator/ramp enable (CONVERT phase)
//   adc_count   ramp/code counter, holds its final code through readout
//   read        one-hot row select during READ, zero elsewhere
//   busy        high whenever not idle
//   frame_done  one-cycle pulse on the last readout cycle of the last row
module pixel_array_sequencer #(
    parameter int ROWS          = 2,
    parameter int ADC_BITS      = 8,
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    parameter int READ_CYCLES   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    output logic                erase,
    output logic                expose,
    output logic                convert,
    output logic [ADC_BITS-1:0] adc_count,
    output logic [ROWS-1:0]     read,
    output logic                busy,
    output logic                frame_done
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [31:0]         ERASE_LAST  = 32'(ERASE_CYCLES - 1);
    localparam logic [31:0]         EXPOSE_LAST = 32'(EXPOSE_CYCLES - 1);
    localparam logic [31:0]         READ_LAST   = 32'(READ_CYCLES - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [ADC_BITS-1:0] ADC_MAX     = {ADC_BITS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ    = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [31:0]         cnt_r;
    logic [31:0]         cnt_s;
    logic [ROW_W-1:0]    row_r;
    logic [ROW_W-1:0]    row_s;
    logic [ADC_BITS-1:0] adc_s;
    logic                erase_s;
    logic                expose_s;
    logic                convert_s;
    logic [ROWS-1:0]     read_s;
    logic                busy_s;
    logic                done_s;

    // Next-state, phase counters and next-cycle output decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        row_s   = row_r;
        adc_s   = adc_count;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_ERASE;
                    cnt_s   = 32'd0;
                    row_s   = {ROW_W{1'b0}};
                    adc_s   = {ADC_BITS{1'b0}};
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ERASE: begin
                if (cnt_r == ERASE_LAST) begin
                    state_s = S_EXPOSE;
                    cnt_s   = 32'd0;
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            S_EXPOSE: begin
                if (cnt_r == EXPOSE_LAST) begin
                    state_s = S_CONVERT;
                    cnt_s   = 32'd0;
                    adc_s   = {ADC_BITS{1'b0}};
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            S_CONVERT: begin
                // The ramp value itself times the phase; stopping at full
                // scale means the counter can never wrap here.
                if (adc_count == ADC_MAX) begin
                    state_s = S_READ;
                    cnt_s   = 32'd0;
                    row_s   = {ROW_W{1'b0}};
                end else begin
                    adc_s = adc_count + {{(ADC_BITS-1){1'b0}}, 1'b1};
                end
            end
            S_READ: begin
                if (cnt_r == READ_LAST) begin
                    cnt_s = 32'd0;
                    if (row_r == ROW_LAST) begin
                        row_s = {ROW_W{1'b0}};
                        if (continuous) begin
                            state_s = S_ERASE;
                            adc_s   = {ADC_BITS{1'b0}};
                        end else begin
                            state_s = S_IDLE;
                        end
                    end else begin
                        row_s = row_r + {{(ROW_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = 32'd0;
                row_s   = {ROW_W{1'b0}};
                adc_s   = {ADC_BITS{1'b0}};
            end
        endcase

        // Outputs are decoded from the next state so the registered copies
        // are exact Moore decodes of the state they accompany.
        erase_s   = (state_s == S_ERASE);
        expose_s  = (state_s == S_EXPOSE);
        convert_s = (state_s == S_CONVERT);
        busy_s    = (state_s != S_IDLE);
        if (state_s == S_READ) begin
            read_s = ROWS'(1'b1) << row_s;
        end else begin
            read_s = {ROWS{1'b0}};
        end
        done_s = (state_s == S_READ) && (row_s == ROW_LAST) && (cnt_s == READ_LAST);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= 32'd0;
            row_r      <= {ROW_W{1'b0}};
            adc_count  <= {ADC_BITS{1'b0}};
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read       <= {ROWS{1'b0}};
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            row_r      <= row_s;
            adc_count  <= adc_s;
            erase      <= erase_s;
            expose     <= expose_s;
            convert    <= convert_s;
            read       <= read_s;
            busy       <= busy_s;
            frame_done <= done_s;
        end
    end

endmodule
